// File: rtl/gnn_input_loader.sv
// Purpose : serial 5-bit beat stream -> staged GNN feature/weight frame, committed atomically.
// Latency : 1 cycle from final-beat acceptance to feat_bus/wgt_bus update and in_ready pulse.
// Backpr. : s_ready low only in WAIT_DONE (after a commit, until gnn_done); otherwise always ready.
// Ports   : clk/rst_n (async active-low); s_valid/s_data/s_last/s_ready beat stream;
//           gnn_done completion pulse; feat_bus/wgt_bus committed frame;
//           in_ready commit pulse; frame_err discard pulse; busy = not IDLE.
module gnn_input_loader #(
    parameter int DATA_W = 5,
    parameter int N_FEAT = 16,
    parameter int N_WGT  = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     s_last,
    output logic                     s_ready,
    input  logic                     gnn_done,
    output logic [N_FEAT*DATA_W-1:0] feat_bus,
    output logic [N_WGT*DATA_W-1:0]  wgt_bus,
    output logic                     in_ready,
    output logic                     frame_err,
    output logic                     busy
);

    localparam int CNT_MAX = ((N_FEAT > N_WGT) ? N_FEAT : N_WGT) - 1;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] FEAT_LAST = CNT_W'(N_FEAT - 1);
    localparam logic [CNT_W-1:0] WGT_LAST  = CNT_W'(N_WGT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEAT,
        S_WGT,
        S_WAIT_DONE,
        S_DRAIN
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       wload_q, wload_d;
    logic [N_FEAT*DATA_W-1:0]   feat_stg_q, feat_stg_d;
    logic [N_WGT*DATA_W-1:0]    wgt_stg_q, wgt_stg_d;
    logic [N_FEAT*DATA_W-1:0]   feat_bus_q, feat_bus_d;
    logic [N_WGT*DATA_W-1:0]    wgt_bus_q, wgt_bus_d;
    logic                       in_ready_q, in_ready_d;
    logic                       frame_err_q, frame_err_d;
    logic                       beat;

    assign s_ready   = (state_q != S_WAIT_DONE);
    assign busy      = (state_q != S_IDLE);
    assign beat      = s_valid && s_ready;
    assign feat_bus  = feat_bus_q;
    assign wgt_bus   = wgt_bus_q;
    assign in_ready  = in_ready_q;
    assign frame_err = frame_err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wload_d     = wload_q;
        feat_stg_d  = feat_stg_q;
        wgt_stg_d   = wgt_stg_q;
        feat_bus_d  = feat_bus_q;
        wgt_bus_d   = wgt_bus_q;
        in_ready_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (beat) begin
                    if (s_last) begin
                        // A header alone is never a valid frame.
                        frame_err_d = 1'b1;
                    end else begin
                        wload_d = s_data[0];
                        cnt_d   = '0;
                        state_d = S_FEAT;
                    end
                end
            end

            S_FEAT: begin
                if (beat) begin
                    feat_stg_d[cnt_q*DATA_W +: DATA_W] = s_data;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == FEAT_LAST) begin
                        if (wload_q) begin
                            if (s_last) begin
                                frame_err_d = 1'b1;
                                state_d     = S_IDLE;
                            end else begin
                                cnt_d   = '0;
                                state_d = S_WGT;
                            end
                        end else if (s_last) begin
                            // Commit from the _d staging so the final beat is included.
                            feat_bus_d = feat_stg_d;
                            in_ready_d = 1'b1;
                            state_d    = S_WAIT_DONE;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end else if (s_last) begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end

            S_WGT: begin
                if (beat) begin
                    wgt_stg_d[cnt_q*DATA_W +: DATA_W] = s_data;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == WGT_LAST) begin
                        if (s_last) begin
                            feat_bus_d = feat_stg_q;
                            wgt_bus_d  = wgt_stg_d;
                            in_ready_d = 1'b1;
                            state_d    = S_WAIT_DONE;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end else if (s_last) begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end

            S_WAIT_DONE: begin
                if (gnn_done) begin
                    state_d = S_IDLE;
                end
            end

            S_DRAIN: begin
                // Overlong frame: swallow beats until the sender closes it.
                if (beat && s_last) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wload_q     <= 1'b0;
            feat_stg_q  <= '0;
            wgt_stg_q   <= '0;
            feat_bus_q  <= '0;
            wgt_bus_q   <= '0;
            in_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wload_q     <= wload_d;
            feat_stg_q  <= feat_stg_d;
            wgt_stg_q   <= wgt_stg_d;
            feat_bus_q  <= feat_bus_d;
            wgt_bus_q   <= wgt_bus_d;
            in_ready_q  <= in_ready_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_gnn_input_loader.sv
// Purpose : self-checking bench for gnn_input_loader (frame table + commit/error scoreboard).
// Latency : expects commit/error pulses one cycle after the closing beat is accepted.
// Backpr. : beats are held until s_ready; gnn_done released per frame after WAIT_DONE checks.
module tb_gnn_input_loader;

    localparam int DW = 5;
    localparam int NF = 16;
    localparam int NW = 24;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s_valid = 1'b0;
    logic [DW-1:0]    s_data = '0;
    logic             s_last = 1'b0;
    logic             s_ready;
    logic             gnn_done = 1'b0;
    logic [NF*DW-1:0] feat_bus;
    logic [NW*DW-1:0] wgt_bus;
    logic             in_ready;
    logic             frame_err;
    logic             busy;

    always #5 clk = ~clk;

    gnn_input_loader #(.DATA_W(DW), .N_FEAT(NF), .N_WGT(NW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .gnn_done  (gnn_done),
        .feat_bus  (feat_bus),
        .wgt_bus   (wgt_bus),
        .in_ready  (in_ready),
        .frame_err (frame_err),
        .busy      (busy)
    );

    typedef struct {
        bit       wload;
        bit [3:0] hdr_junk;
        int       nbeats;
        int       last_at;
        int       fseed;
        int       fstride;
        int       wseed;
        int       wstride;
        bit       gaps;
        bit       done_early;
        bit       exp_commit;
    } frame_t;

    typedef struct {
        bit               commit;
        logic [NF*DW-1:0] feat;
        logic [NW*DW-1:0] wgt;
    } exp_t;

    exp_t             sb[$];
    logic [NF*DW-1:0] m_feat;
    logic [NW*DW-1:0] m_wgt;
    int               n_vec = 0;
    int               n_bad = 0;
    frame_t           tbl[9];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input frame_t f, input int i);
        if (i == 0) return {f.hdr_junk, f.wload};
        if (i <= NF) return DW'(f.fseed + f.fstride * (i - 1));
        if (f.wload && i <= NF + NW) return DW'(f.wseed + f.wstride * (i - 1 - NF));
        return DW'(i * 7);
    endfunction

    task automatic send_beat(input logic [DW-1:0] d, input bit last, input bit gaps);
        int t;
        bit ok;
        if (gaps) begin
            while ($urandom_range(1) == 0) begin
                s_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        t = 0;
        do begin
            ok = s_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!ok && t < 50);
        if (!ok) check("beat_accept_timeout", 0, 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (in_ready || frame_err) begin
                if (sb.size() == 0) begin
                    check("unexpected_event", {in_ready, frame_err}, 0);
                end else begin
                    e = sb.pop_front();
                    check("event_kind", {in_ready, frame_err}, e.commit ? 2'b10 : 2'b01);
                    if (e.commit) begin
                        check("feat_bus", feat_bus, e.feat);
                        check("wgt_bus", wgt_bus, e.wgt);
                    end
                end
            end
        end
    endtask

    // Sends beats 0..upto-1; only a complete frame gets an expectation and tail checks.
    task automatic run_frame(input frame_t f, input int upto);
        exp_t e;
        bit   full;
        full = (upto >= f.nbeats);
        if (full) begin
            e.commit = f.exp_commit;
            if (f.exp_commit) begin
                for (int k = 0; k < NF; k++) m_feat[k*DW +: DW] = beat_data(f, k + 1);
                if (f.wload)
                    for (int j = 0; j < NW; j++) m_wgt[j*DW +: DW] = beat_data(f, j + 1 + NF);
            end
            e.feat = m_feat;
            e.wgt  = m_wgt;
            sb.push_back(e);
        end
        for (int i = 0; i < f.nbeats && i < upto; i++) begin
            send_beat(beat_data(f, i), (i == f.last_at), f.gaps);
            if (i < f.nbeats - 1) check("busy_mid_frame", busy, 1);
        end
        if (!full) return;
        if (f.exp_commit) begin
            check("in_ready_pulse", in_ready, 1);
            check("s_ready_in_commit_cycle", s_ready, 0);
            if (f.done_early) begin
                gnn_done = 1'b1;
                @(posedge clk);
                #1;
                gnn_done = 1'b0;
                check("s_ready_after_early_done", s_ready, 1);
                check("in_ready_one_cycle", in_ready, 0);
            end else begin
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    check("s_ready_wait_done", s_ready, 0);
                    check("busy_wait_done", busy, 1);
                end
                gnn_done = 1'b1;
                @(posedge clk);
                #1;
                gnn_done = 1'b0;
                check("s_ready_after_done", s_ready, 1);
                check("busy_after_done", busy, 0);
            end
        end else begin
            check("frame_err_pulse", frame_err, 1);
            check("in_ready_on_err", in_ready, 0);
            check("busy_after_err", busy, 0);
            @(posedge clk);
            #1;
            check("frame_err_one_cycle", frame_err, 0);
            check("feat_bus_kept", feat_bus, m_feat);
            check("wgt_bus_kept", wgt_bus, m_wgt);
        end
    endtask

    initial begin
        fork
            monitor();
            begin
                #500000;
                $display("FAIL watchdog: got timeout expected finish");
                $fatal(1);
            end
        join_none

        //            wl junk  nb  last fs fst ws wst gap early commit
        tbl[0] = '{0, 4'h0, 17, 16,  1, 1, 0, 0, 0, 0, 1};
        tbl[1] = '{1, 4'h0, 41, 40, 31, 0, 0, 1, 0, 0, 1};
        tbl[2] = '{0, 4'hA, 17, 16,  5, 3, 0, 0, 0, 0, 1};
        tbl[3] = '{0, 4'h0,  6,  5,  9, 1, 0, 0, 0, 0, 0};
        tbl[4] = '{0, 4'h3, 20, 19,  2, 5, 0, 0, 0, 0, 0};
        tbl[5] = '{1, 4'h0, 41, 40, 31, 0, 0, 1, 1, 1, 1};
        tbl[6] = '{0, 4'hF,  1,  0,  0, 0, 0, 0, 0, 0, 0};
        tbl[7] = '{1, 4'h5, 26, 25,  4, 1, 3, 2, 0, 0, 0};
        tbl[8] = '{1, 4'h0, 17, 16,  4, 1, 3, 2, 0, 0, 0};

        m_feat = '0;
        m_wgt  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_feat_bus", feat_bus, 0);
        check("rst_wgt_bus", wgt_bus, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_s_ready", s_ready, 1);

        for (int i = 0; i < 9; i++) begin
            run_frame(tbl[i], tbl[i].nbeats);
            if (i == 0) begin
                check("feat0_first", feat_bus[4:0], 5'd1);
                check("feat15_last", feat_bus[79:75], 5'd16);
                check("wgt_untouched", wgt_bus, 0);
            end
            if (i == 1) begin
                check("w04", wgt_bus[4:0], 5'd0);
                check("w79", wgt_bus[119:115], 5'd23);
                check("feat_all_ones", feat_bus, {NF{5'h1F}});
            end
        end

        // Asynchronous reset in the middle of a weight frame.
        run_frame(tbl[1], 31);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_feat_bus", feat_bus, 0);
        check("arst_wgt_bus", wgt_bus, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_frame_err", frame_err, 0);
        check("arst_busy", busy, 0);
        m_feat = '0;
        m_wgt  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(tbl[1], tbl[1].nbeats);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/gnn_input_loader.md
Name: gnn_input_loader

Overview:
- Stream-to-parallel front end for the 4-node GNN top.
- Accepts a serial 5-bit beat stream over a valid/ready handshake and assembles the 16 node features and, optionally, the 24 layer weights into staging registers.
- Commits a complete frame atomically to parallel buses that drive the GNN inputs, then pulses in_ready for one cycle.
- Holds off the next frame until the GNN signals completion.

Parameters:
- DATA_W, 5, width of each feature/weight beat (signed two's complement).
- N_FEAT, 16, feature beats per frame (4 nodes x 4 features).
- N_WGT, 24, weight beats when a weight load is requested (16 layer-1 + 8 layer-2).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  beat valid
- s_data  in  DATA_W  beat payload
- s_last  in  1  final beat of frame
- s_ready  out  1  loader can accept a beat
- gnn_done  in  1  single-cycle pulse: GNN outputs consumed, next frame allowed
- feat_bus  out  N_FEAT*DATA_W  features; beat k lands at [k*DATA_W +: DATA_W], k = node*4 + feature
- wgt_bus  out  N_WGT*DATA_W  weights; order w04,w14,w24,w34,w05..w35,w06..w36,w07..w37,w48..w78,w49..w79
- in_ready  out  1  one-cycle pulse: committed frame valid
- frame_err  out  1  one-cycle pulse: malformed frame discarded
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous: all outputs 0, staging registers 0, beat counter 0, state IDLE. Reset mid-frame discards the partial frame; committed buses also return to 0.
- Beat transfer occurs when s_valid & s_ready are both high at a rising edge.
- Frame format:
  - beat 0 is the header; s_data[0] = wload, other bits ignored.
  - beats 1..N_FEAT are features.
  - if wload=1, the next N_WGT beats are weights.
  - Total length is 17 beats (wload=0) or 41 beats (wload=1).
- States:
  - IDLE: s_ready=1. Header accepted -> latch wload, clear counter -> FEAT. A header carrying s_last=1 -> frame_err, stay IDLE.
  - FEAT: s_ready=1. Each beat writes staging feature [cnt] and increments cnt.
  - WGT: s_ready=1. Each beat writes staging weight [cnt].
  - WAIT_DONE: s_ready=0. gnn_done -> IDLE.
  - DRAIN: s_ready=1. Beats are discarded until the beat with s_last=1 -> frame_err pulse, IDLE.
- Final-beat handling:
  - Expected final beat (last feature when wload=0, last weight when wload=1) accepted with s_last=1 -> at that same edge:
    - staging features -> feat_bus;
    - staging weights -> wgt_bus only if wload=1, otherwise wgt_bus is retained;
    - in_ready set to 1 for exactly one cycle;
    - go to WAIT_DONE.
  - Outputs are therefore visible in the cycle after acceptance (latency 1).
  - The final beat's own data is included in the commit.
  - Expected final beat without s_last -> DRAIN.
- Early termination: s_last=1 on any beat before the expected final beat -> discard frame, frame_err pulse next cycle, go to IDLE. feat_bus and wgt_bus are unchanged.
- gnn_done outside WAIT_DONE is ignored. If gnn_done coincides with the in_ready cycle, it is accepted and the FSM returns to IDLE; the next header can be taken that cycle.
- feat_bus and wgt_bus change only on commit; they are stable at all other times, including during WAIT_DONE and error handling.
- Widths: the counter is sized to hold max(N_FEAT, N_WGT)-1. No arithmetic is performed on data; beats are stored verbatim.

Test Plan:
- Reset, then a 17-beat frame: header 0x00, features k=1..16 with s_data=k -> in_ready pulses one cycle after the 17th accept; feat_bus[4:0]=1 and feat_bus[79:75]=16 (0x10); wgt_bus=0; s_ready=0 until gnn_done.
- 41-beat frame: header 0x01, features all 0x1F (-1), weights j=0..23 with value j -> wgt_bus[4:0]=0 (w04), wgt_bus[119:115]=23 (w79); in_ready pulses once. A following 17-beat frame leaves wgt_bus unchanged.
- s_last asserted on feature beat 5 -> frame_err pulses one cycle; in_ready stays 0; feat_bus keeps prior values; the next header is accepted.
- wload=0 frame with s_last missing on beat 17, then 3 extra beats with s_last on the third -> busy held in DRAIN, frame_err pulses once, no commit.
- s_valid toggled randomly (50%) across a 41-beat frame -> committed data identical to the gap-free run; gnn_done asserted in the in_ready cycle -> s_ready=1 on the next cycle.
- rst_n asserted asynchronously at beat 30 of a weight frame -> all outputs 0 immediately; a subsequent full frame commits correctly.
